// File: rtl/pc_src_ctrl_pkg.sv
// Shared PCSrc codes, instruction classes and trap FSM encoding for the next-PC sequencer.
package pc_ctrl_pkg;

    localparam logic [2:0] PC_SEQ    = 3'd0;
    localparam logic [2:0] PC_BRANCH = 3'd1;
    localparam logic [2:0] PC_JUMP   = 3'd2;
    localparam logic [2:0] PC_JR     = 3'd3;
    localparam logic [2:0] PC_ILLOP  = 3'd4;
    localparam logic [2:0] PC_XADR   = 3'd5;
    localparam logic [2:0] PC_HOLD   = 3'd6;

    localparam logic [2:0] OP_SEQ     = 3'd0;
    localparam logic [2:0] OP_BRANCH  = 3'd1;
    localparam logic [2:0] OP_JUMP    = 3'd2;
    localparam logic [2:0] OP_JR      = 3'd3;
    localparam logic [2:0] OP_ILLEGAL = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_TRAP_WAIT = 2'd1,
        ST_KERNEL    = 2'd2
    } state_t;

    // Classes 5..7 are unassigned encodings and trap like ILLEGAL.
    function automatic logic is_illegal(input logic [2:0] op);
        return op >= OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/pc_src_ctrl_if.sv
// Decode-side bundle between the core and the next-PC sequencer.
interface pc_src_ctrl_if;
    logic       instr_valid;
    logic       stall;
    logic [2:0] op_class;
    logic       pc_31;
    logic       irq;
    logic [2:0] pc_src;
    logic       kill;
    logic       xp_we;
    logic       xp_sel;
    logic       irq_ack;
    logic       trap_err;
    logic [1:0] state;

    modport master (
        output instr_valid, stall, op_class, pc_31, irq,
        input  pc_src, kill, xp_we, xp_sel, irq_ack, trap_err, state
    );

    modport slave (
        input  instr_valid, stall, op_class, pc_31, irq,
        output pc_src, kill, xp_we, xp_sel, irq_ack, trap_err, state
    );
endinterface

// File: rtl/pc_src_ctrl_trap_fsm.sv
// Trap entry/exit tracker: RUN -> TRAP_WAIT -> KERNEL -> RUN, with a bounded wait for
// kernel mode to become visible and a sticky error when that wait expires.
module pc_trap_fsm
    import pc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 3,
    parameter int CNT_W    = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   stall_i,
    input  logic   trap_i,
    input  logic   pc_31_i,
    output state_t state_o,
    output logic   irq_en_o,
    output logic   trap_err_o
);

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (!stall_i) begin
            if (trap_i) begin
                state_d = ST_TRAP_WAIT;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_RUN: ;
                    ST_TRAP_WAIT: begin
                        if (pc_31_i) begin
                            state_d = ST_KERNEL;
                            cnt_d   = '0;
                        end else begin
                            // Kernel bit never showed up: give up and flag it.
                            cnt_d = cnt_q + 1'b1;
                            if (cnt_d == WAIT_LIM) begin
                                state_d = ST_RUN;
                                err_d   = 1'b1;
                            end
                        end
                    end
                    ST_KERNEL: begin
                        if (!pc_31_i) state_d = ST_RUN;
                    end
                    default: state_d = ST_RUN;
                endcase
            end
        end
    end

    assign state_o    = state_q;
    assign irq_en_o   = (state_q == ST_RUN);
    assign trap_err_o = err_q;

endmodule

// File: rtl/pc_src_ctrl.sv
// Next-PC sequencer: pending-interrupt latch, output priority mux and trap FSM.
// Optional macro PC_IRQ_SYNC_EN inserts a two-flop synchronizer on irq.
module pc_src_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 3,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_src_ctrl_if.slave   bus
);

    logic   irq_in;
    logic   irq_pend_q, irq_pend_d;
    logic   irq_en;
    logic   trap;
    logic   ack;
    state_t fsm_state;

`ifdef PC_IRQ_SYNC_EN
    logic irq_s1_q, irq_s2_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_s1_q <= 1'b0;
            irq_s2_q <= 1'b0;
        end else begin
            irq_s1_q <= bus.irq;
            irq_s2_q <= irq_s1_q;
        end
    end

    assign irq_in = irq_s2_q;
`else
    assign irq_in = bus.irq;
`endif

    // A new request in the acknowledge cycle must not be lost.
    assign irq_pend_d = irq_in | (irq_pend_q & ~ack);

    always_ff @(posedge clk) begin
        if (!reset) irq_pend_q <= 1'b0;
        else        irq_pend_q <= irq_pend_d;
    end

    always_comb begin
        bus.pc_src = PC_SEQ;
        bus.kill   = 1'b0;
        bus.xp_we  = 1'b0;
        bus.xp_sel = 1'b0;
        ack        = 1'b0;
        trap       = 1'b0;
        if (!reset) begin
            bus.pc_src = PC_SEQ;
        end else if (bus.stall) begin
            bus.pc_src = PC_HOLD;
            bus.kill   = 1'b1;
        end else if (!bus.instr_valid) begin
            bus.pc_src = PC_SEQ;
        end else if (is_illegal(bus.op_class)) begin
            bus.pc_src = PC_ILLOP;
            bus.kill   = 1'b1;
            bus.xp_we  = 1'b1;
            trap       = 1'b1;
        end else if (irq_pend_q && irq_en && !bus.pc_31) begin
            // Interrupted instruction is re-executed on return, so save PC itself.
            bus.pc_src = PC_XADR;
            bus.kill   = 1'b1;
            bus.xp_we  = 1'b1;
            bus.xp_sel = 1'b1;
            ack        = 1'b1;
            trap       = 1'b1;
        end else begin
            bus.pc_src = bus.op_class;
        end
    end

    assign bus.irq_ack = ack;
    assign bus.state   = fsm_state;

    pc_trap_fsm #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (bus.stall),
        .trap_i     (trap),
        .pc_31_i    (bus.pc_31),
        .state_o    (fsm_state),
        .irq_en_o   (irq_en),
        .trap_err_o (bus.trap_err)
    );

endmodule

// File: tb/tb_pc_src_ctrl.sv
// Scoreboard bench for pc_src_ctrl: stimulus pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_src_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pc_src_ctrl_if bus();

    pc_src_ctrl #(.WAIT_MAX(3), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic       chk;
        logic [9:0] exp;
    } sb_t;

    sb_t sb[$];
    int  total = 0;
    int  bad   = 0;

    // {pc_src[2:0], kill, xp_we, xp_sel, irq_ack, state[1:0], trap_err}
    function automatic logic [9:0] mk(input logic [2:0] pc, input logic k, input logic w,
                                      input logic s, input logic a, input logic [1:0] st,
                                      input logic e);
        return {pc, k, w, s, a, st, e};
    endfunction

    task automatic cyc(input string nm, input logic rn, input logic iv, input logic stl,
                       input logic [2:0] op, input logic p31, input logic irqv,
                       input logic chk, input logic [9:0] exp);
        sb_t e;
        @(posedge clk);
        #1;
        reset           = rn;
        bus.instr_valid = iv;
        bus.stall       = stl;
        bus.op_class    = op;
        bus.pc_31       = p31;
        bus.irq         = irqv;
        e.name = nm;
        e.chk  = chk;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_t e;
            logic [9:0] act;
            e   = sb.pop_front();
            act = {bus.pc_src, bus.kill, bus.xp_we, bus.xp_sel, bus.irq_ack, bus.state, bus.trap_err};
            if (e.chk) begin
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got pc=%0d kill=%b we=%b sel=%b ack=%b st=%0d err=%b want pc=%0d kill=%b we=%b sel=%b ack=%b st=%0d err=%b",
                             e.name, act[9:7], act[6], act[5], act[4], act[3], act[2:1], act[0],
                             e.exp[9:7], e.exp[6], e.exp[5], e.exp[4], e.exp[3], e.exp[2:1], e.exp[0]);
                end
            end
        end
    end

    initial begin
        bus.instr_valid = 1'b1;
        bus.stall       = 1'b0;
        bus.op_class    = 3'd0;
        bus.pc_31       = 1'b0;
        bus.irq         = 1'b0;

        cyc("rst1", 0, 1, 0, 3'd0, 0, 0, 0, mk(0,0,0,0,0,0,0));
        cyc("rst2", 0, 1, 0, 3'd2, 0, 1, 1, mk(0,0,0,0,0,0,0));
`ifdef PC_IRQ_SYNC_EN
        cyc("sync_t0",  1, 1, 0, 3'd0, 0, 1, 1, mk(0,0,0,0,0,0,0));
        cyc("sync_t1",  1, 1, 0, 3'd0, 0, 1, 1, mk(0,0,0,0,0,0,0));
        cyc("sync_t2",  1, 1, 0, 3'd0, 0, 1, 1, mk(0,0,0,0,0,0,0));
        cyc("sync_t3",  1, 1, 0, 3'd0, 0, 0, 1, mk(5,1,1,1,1,0,0));
        cyc("sync_rst", 0, 1, 0, 3'd0, 0, 1, 1, mk(0,0,0,0,0,1,0));
        cyc("sync_a",   1, 1, 0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,0,0));
        cyc("sync_b",   1, 1, 0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,0,0));
        cyc("sync_c",   1, 1, 0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,0,0));
        cyc("sync_d",   1, 1, 0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,0,0));
`else
        // normal flow out of reset, then an interrupt that times out in TRAP_WAIT
        cyc("run_seq",   1, 1, 0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,0,0));
        cyc("irq_rise",  1, 1, 0, 3'd2, 0, 1, 1, mk(2,0,0,0,0,0,0));
        cyc("irq_take",  1, 1, 0, 3'd2, 0, 0, 1, mk(5,1,1,1,1,0,0));
        cyc("wait0",     1, 1, 0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,1,0));
        cyc("wait1",     1, 1, 0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,1,0));
        cyc("wait2",     1, 1, 0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,1,0));
        cyc("timeout",   1, 1, 0, 3'd0, 0, 1, 1, mk(0,0,0,0,0,0,1));
        // illegal beats pending irq; irq taken after kernel exit
        cyc("ill_pend",  1, 1, 0, 3'd4, 0, 0, 1, mk(4,1,1,0,0,0,1));
        cyc("tw_k",      1, 1, 0, 3'd0, 1, 0, 1, mk(0,0,0,0,0,1,1));
        cyc("k_jr",      1, 1, 0, 3'd3, 0, 0, 1, mk(3,0,0,0,0,2,1));
        cyc("k_exit_irq",1, 1, 0, 3'd0, 0, 0, 1, mk(5,1,1,1,1,0,1));
        cyc("tw_k2",     1, 1, 0, 3'd0, 1, 0, 1, mk(0,0,0,0,0,1,1));
        cyc("k_jr2",     1, 1, 0, 3'd3, 0, 0, 1, mk(3,0,0,0,0,2,1));
        // stall holds PC and keeps the pending interrupt
        cyc("st_irq",    1, 1, 0, 3'd0, 0, 1, 1, mk(0,0,0,0,0,0,1));
        cyc("stall1",    1, 1, 1, 3'd2, 0, 0, 1, mk(6,1,0,0,0,0,1));
        cyc("stall2",    1, 1, 1, 3'd2, 0, 0, 1, mk(6,1,0,0,0,0,1));
        cyc("unstall",   1, 1, 0, 3'd0, 0, 0, 1, mk(5,1,1,1,1,0,1));
        // irq pulse while in kernel mode is held until return
        cyc("to_k",      1, 1, 0, 3'd0, 1, 0, 1, mk(0,0,0,0,0,1,1));
        cyc("k_pulse",   1, 1, 0, 3'd0, 1, 1, 1, mk(0,0,0,0,0,2,1));
        cyc("k_masked",  1, 1, 0, 3'd0, 1, 0, 1, mk(0,0,0,0,0,2,1));
        cyc("k_jr3",     1, 1, 0, 3'd3, 0, 0, 1, mk(3,0,0,0,0,2,1));
        cyc("k_irq_take",1, 1, 0, 3'd0, 0, 0, 1, mk(5,1,1,1,1,0,1));
        // stall freezes the wait counter
        cyc("tw_stall",  1, 1, 1, 3'd0, 0, 0, 1, mk(6,1,0,0,0,1,1));
        cyc("tw_c0",     1, 1, 0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,1,1));
        cyc("tw_c1",     1, 1, 0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,1,1));
        cyc("tw_c2",     1, 1, 0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,1,1));
        // bubbles never trap; op_class 7 traps like ILLEGAL and wins over irq
        cyc("bub_irq",   1, 0, 0, 3'd7, 0, 1, 1, mk(0,0,0,0,0,0,1));
        cyc("bub_ill",   1, 0, 0, 3'd7, 0, 0, 1, mk(0,0,0,0,0,0,1));
        cyc("op7_ill",   1, 1, 0, 3'd7, 0, 0, 1, mk(4,1,1,0,0,0,1));
        cyc("tw_k3",     1, 1, 0, 3'd0, 1, 0, 1, mk(0,0,0,0,0,1,1));
        cyc("k_jr4",     1, 1, 0, 3'd3, 0, 0, 1, mk(3,0,0,0,0,2,1));
        cyc("br_irq",    1, 1, 0, 3'd1, 0, 0, 1, mk(5,1,1,1,1,0,1));
        // reset mid-trap aborts to RUN, clears trap_err and the pending irq
        cyc("rst_mid",   0, 1, 0, 3'd1, 0, 1, 1, mk(0,0,0,0,0,1,1));
        cyc("post_rst",  1, 1, 0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,0,0));
        cyc("post_br",   1, 1, 0, 3'd1, 0, 0, 1, mk(1,0,0,0,0,0,0));
`endif
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
